regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb_pkg.sv | 5 +
 rtl/regfile_wr_arb_rr_arb2.sv | 18 +
 rtl/regfile_wr_arb.sv | 114 +++++++++++
 tb/tb_regfile_wr_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arb_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states and requester identities.
package regfile_wr_arb_pkg;
   typedef enum logic {INIT, RUN} state_t;
   typedef enum logic {REQ_ALU, REQ_MEM} req_t;
endpackage

// File: rtl/regfile_wr_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the one not granted last wins.
// Purely combinational, no backpressure of its own.
module rr_arb2
   import regfile_wr_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_t       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last == REQ_MEM) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port (1-cycle latency),
// zero-filling the file after reset or init_req; readies low while filling, otherwise round-robin.
module regfile_wr_arb
   import regfile_wr_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ADDR  = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 init_req,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [ADDR-1:0]      alu_rd,
   input  logic [WIDTH-1:0]     alu_wdata,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [ADDR-1:0]      mem_rd,
   input  logic [WIDTH-1:0]     mem_wdata,
   output logic                 wr_en,
   output logic [ADDR-1:0]      wr_rd,
   output logic [WIDTH-1:0]     wr_data,
   output logic [2**ADDR-1:0]   busy,
   output logic                 init_done
);

   // Fill index carries one extra bit so "all entries issued" is distinguishable from index 0.
   localparam logic [ADDR:0] FILL_END = {1'b1, {ADDR{1'b0}}};
   localparam logic [ADDR:0] ONE      = {{ADDR{1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [ADDR:0]    index;
   req_t             last_grant;
   logic [1:0]       gnt;
   logic             alu_xfer;
   logic             mem_xfer;
   logic [ADDR-1:0]  sel_rd;
   logic [WIDTH-1:0] sel_data;

   rr_arb2 u_arb (
      .req  ({mem_valid, alu_valid}),
      .last (last_grant),
      .gnt  (gnt)
   );

   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (state == RUN) begin
         alu_ready = gnt[0];
         mem_ready = gnt[1];
      end
   end

   assign alu_xfer = alu_valid & alu_ready;
   assign mem_xfer = mem_valid & mem_ready;
   assign sel_rd   = mem_xfer ? mem_rd    : alu_rd;
   assign sel_data = mem_xfer ? mem_wdata : alu_wdata;

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (index == FILL_END) state_nxt = RUN;
         RUN:     if (init_req) state_nxt = INIT;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= INIT;
         index      <= '0;
         last_grant <= REQ_MEM;
         wr_en      <= 1'b0;
         wr_rd      <= '0;
         wr_data    <= '0;
      end else begin
         state <= state_nxt;
         wr_en <= 1'b0;
         if (state == INIT) begin
            if (index != FILL_END) begin
               wr_en   <= 1'b1;
               wr_rd   <= index[ADDR-1:0];
               wr_data <= '0;
               index   <= index + ONE;
            end
         end else begin
            if (init_req) begin
               index <= '0;
            end
            // Writes to register 0 are consumed but never reach the file.
            if (alu_xfer || mem_xfer) begin
               last_grant <= mem_xfer ? REQ_MEM : REQ_ALU;
               if (sel_rd != '0) begin
                  wr_en   <= 1'b1;
                  wr_rd   <= sel_rd;
                  wr_data <= sel_data;
               end
            end
         end
      end
   end

   always_comb begin
      busy = '0;
      if (state == RUN && wr_en) begin
         busy[wr_rd] = 1'b1;
      end
   end

   assign init_done = (state == RUN);

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: a cycle-level behavioural model checked every negedge,
// plus hand-computed literal expectations for the fill, handshake and reset scenarios.
module tb_regfile_wr_arb;
   localparam int WIDTH = 32;
   localparam int ADDR  = 5;
   localparam int NENT  = 32;

   logic              clk;
   logic              reset_n;
   logic              init_req;
   logic              alu_valid, alu_ready;
   logic [ADDR-1:0]   alu_rd;
   logic [WIDTH-1:0]  alu_wdata;
   logic              mem_valid, mem_ready;
   logic [ADDR-1:0]   mem_rd;
   logic [WIDTH-1:0]  mem_wdata;
   logic              wr_en;
   logic [ADDR-1:0]   wr_rd;
   logic [WIDTH-1:0]  wr_data;
   logic [NENT-1:0]   busy;
   logic              init_done;

   int errors = 0;
   int checks = 0;

   regfile_wr_arb #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .init_req  (init_req),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_wdata (alu_wdata),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_wdata (mem_wdata),
      .wr_en     (wr_en),
      .wr_rd     (wr_rd),
      .wr_data   (wr_data),
      .busy      (busy),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: filling flag, count of fill writes issued, who won last, and the expected write port.
   logic              m_run      = 1'b0;
   int                m_fill     = 0;
   logic              m_last_mem = 1'b1;
   logic              e_en       = 1'b0;
   logic [ADDR-1:0]   e_rd       = '0;
   logic [WIDTH-1:0]  e_data     = '0;

   wire exp_alu_rdy = m_run && alu_valid && (!mem_valid || m_last_mem);
   wire exp_mem_rdy = m_run && mem_valid && (!alu_valid || !m_last_mem);
   wire [ADDR-1:0]  win_rd   = exp_mem_rdy ? mem_rd    : alu_rd;
   wire [WIDTH-1:0] win_data = exp_mem_rdy ? mem_wdata : alu_wdata;
   wire [NENT-1:0]  exp_busy = (m_run && e_en) ? (32'd1 << e_rd) : 32'd0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_run      <= 1'b0;
         m_fill     <= 0;
         m_last_mem <= 1'b1;
         e_en       <= 1'b0;
         e_rd       <= '0;
         e_data     <= '0;
      end else if (!m_run) begin
         if (m_fill < NENT) begin
            e_en   <= 1'b1;
            e_rd   <= m_fill[ADDR-1:0];
            e_data <= '0;
            m_fill <= m_fill + 1;
         end else begin
            e_en  <= 1'b0;
            m_run <= 1'b1;
         end
      end else begin
         e_en <= 1'b0;
         if (exp_alu_rdy || exp_mem_rdy) begin
            m_last_mem <= exp_mem_rdy;
            if (win_rd != 0) begin
               e_en   <= 1'b1;
               e_rd   <= win_rd;
               e_data <= win_data;
            end
         end
         if (init_req) begin
            m_run  <= 1'b0;
            m_fill <= 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_alu_ready", alu_ready, exp_alu_rdy);
      chk("m_mem_ready", mem_ready, exp_mem_rdy);
      chk("m_wr_en",     wr_en,     e_en);
      chk("m_wr_rd",     wr_rd,     e_rd);
      chk("m_wr_data",   wr_data,   e_data);
      chk("m_busy",      busy,      exp_busy);
      chk("m_init_done", init_done, m_run);
   end

   // Expects the next rising edge to issue fill index 0; optionally pulses init_req mid-fill.
   task automatic check_fill(input string tag, input int pulse_at);
      for (int i = 0; i < NENT; i++) begin
         @(negedge clk);
         chk({tag, "_wr_en"},     wr_en,     1);
         chk({tag, "_wr_rd"},     wr_rd,     i);
         chk({tag, "_wr_data"},   wr_data,   0);
         chk({tag, "_busy"},      busy,      0);
         chk({tag, "_init_done"}, init_done, 0);
         chk({tag, "_alu_ready"}, alu_ready, 0);
         chk({tag, "_mem_ready"}, mem_ready, 0);
         init_req = (i == pulse_at);
      end
      @(negedge clk);
      init_req = 1'b0;
      chk({tag, "_done"},     init_done, 1);
      chk({tag, "_idle_en"},  wr_en,     0);
   endtask

   initial begin
      reset_n   = 1'b0;
      init_req  = 1'b0;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_wdata = '0;
      mem_valid = 1'b0;
      mem_rd    = '0;
      mem_wdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_wr_en",     wr_en,     0);
      chk("rst_wr_rd",     wr_rd,     0);
      chk("rst_wr_data",   wr_data,   0);
      chk("rst_busy",      busy,      0);
      chk("rst_init_done", init_done, 0);
      #2 reset_n = 1'b1;

      check_fill("fill", -1);

      // Tie held four cycles: ALU wins first after reset, then alternation.
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h0000_0011;
            mem_valid = 1'b1; mem_rd = 5'd2; mem_wdata = 32'h0000_0022;
         end
         if (k == 4) begin
            alu_valid = 1'b0;
            mem_valid = 1'b0;
         end
         @(negedge clk);
         if (k < 4) begin
            chk("tie_alu_ready", alu_ready, (k % 2 == 0) ? 1 : 0);
            chk("tie_mem_ready", mem_ready, (k % 2 == 1) ? 1 : 0);
         end
         if (k > 0) begin
            chk("tie_wr_en", wr_en, 1);
            chk("tie_wr_rd", wr_rd, ((k - 1) % 2 == 0) ? 1 : 2);
            chk("tie_wr_data", wr_data, ((k - 1) % 2 == 0) ? 32'h11 : 32'h22);
         end
      end

      @(posedge clk); #1;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("alu_ready", alu_ready, 1);
      chk("alu_mem_ready", mem_ready, 0);
      @(posedge clk); #1;
      alu_valid = 1'b0;
      @(negedge clk);
      chk("alu_wr_en",   wr_en,   1);
      chk("alu_wr_rd",   wr_rd,   5);
      chk("alu_wr_data", wr_data, 32'hDEAD_BEEF);
      chk("alu_busy",    busy,    32'h0000_0020);

      @(posedge clk); #1;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_wdata = 32'h0000_1234;
      @(negedge clk);
      chk("rd0_mem_ready", mem_ready, 1);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      chk("rd0_wr_en", wr_en, 0);
      chk("rd0_busy",  busy,  0);
      chk("rd0_hold",  wr_data, 32'hDEAD_BEEF);

      @(posedge clk); #1;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_wdata = 32'h0000_0077;
      init_req  = 1'b1;
      @(negedge clk);
      chk("reinit_alu_ready", alu_ready, 1);
      @(posedge clk); #1;
      init_req  = 1'b0;
      alu_rd    = 5'd9;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_wdata = 32'h0000_0033;
      @(negedge clk);
      chk("reinit_wr_en",     wr_en,     1);
      chk("reinit_wr_rd",     wr_rd,     7);
      chk("reinit_wr_data",   wr_data,   32'h77);
      chk("reinit_init_done", init_done, 0);
      chk("reinit_alu_ready", alu_ready, 0);
      check_fill("refill", 5);

      @(posedge clk); #1;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      init_req  = 1'b1;
      @(posedge clk); #1;
      init_req = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk("pre_rst_wr_rd", wr_rd, 10);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_wr_en",     wr_en,     0);
      chk("arst_wr_rd",     wr_rd,     0);
      chk("arst_wr_data",   wr_data,   0);
      chk("arst_busy",      busy,      0);
      chk("arst_init_done", init_done, 0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      check_fill("after_rst", -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
